// File: rtl/ex_stage_pkg.sv
// Shared types and encodings for the execute stage of the 16-bit core.
// ALU and branch codes must stay aligned with the ALU and decoder.
package ex_stage_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 3;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_NOT = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRA = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQZ  = 2'd1,
    BR_NEZ  = 2'd2,
    BR_JMP  = 2'd3
  } br_e;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    alu_op_e           alu_ctrl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc_next;
    logic              use_imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    br_e               branch;
  } idex_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
  } exmem_t;

endpackage

// File: rtl/ex_stage_fwd_mux.sv
// Operand forwarding select: MEM result beats WB result beats register file.
// Register zero always reads as zero regardless of any pending write.
module fwd_mux
  import ex_stage_pkg::*;
(
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data_c
);

  // addr != 0 together with equality implies the source rd is nonzero
  always_comb begin
    data_c = rf_data;
    if (addr == REG_ZERO) begin
      data_c = '0;
    end else if (mem_we && (mem_rd == addr)) begin
      data_c = mem_data;
    end else if (wb_we && (wb_rd == addr)) begin
      data_c = wb_data;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU drive, branch
// resolution, load-use detection and the EX/MEM register.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              IdValid,
  input  logic [2:0]        IdAluCtrl,
  input  logic [REG_AW-1:0] IdRs1,
  input  logic [REG_AW-1:0] IdRs2,
  input  logic [REG_AW-1:0] IdRd,
  input  logic [DATA_W-1:0] IdRdata1,
  input  logic [DATA_W-1:0] IdRdata2,
  input  logic [DATA_W-1:0] IdImm,
  input  logic              IdUseImm,
  input  logic              IdRegWrite,
  input  logic              IdMemRead,
  input  logic              IdMemWrite,
  input  logic [1:0]        IdBranch,
  input  logic [DATA_W-1:0] IdPcNext,
  input  logic              MemRegWrite,
  input  logic [REG_AW-1:0] MemRd,
  input  logic [DATA_W-1:0] MemData,
  input  logic              WbRegWrite,
  input  logic [REG_AW-1:0] WbRd,
  input  logic [DATA_W-1:0] WbData,
  output logic [DATA_W-1:0] Src1,
  output logic [DATA_W-1:0] Src2,
  output logic [2:0]        AluCtrl1,
  input  logic [DATA_W-1:0] Result1,
  input  logic              Zero1,
  output logic              ExMemValid,
  output logic              ExMemRegWrite,
  output logic              ExMemMemRead,
  output logic              ExMemMemWrite,
  output logic [DATA_W-1:0] ExMemResult,
  output logic [DATA_W-1:0] ExMemStoreData,
  output logic [REG_AW-1:0] ExMemRd,
  output logic              BranchTaken,
  output logic [DATA_W-1:0] BranchTarget,
  output logic              LoadUseStall
);

  idex_t             idex_q, idex_d;
  exmem_t            exmem_q, exmem_d;
  logic [DATA_W-1:0] fwd1_c, fwd2_c;

  fwd_mux u_fwd_rs1 (
    .addr    (idex_q.rs1),
    .rf_data (idex_q.rdata1),
    .mem_we  (MemRegWrite),
    .mem_rd  (MemRd),
    .mem_data(MemData),
    .wb_we   (WbRegWrite),
    .wb_rd   (WbRd),
    .wb_data (WbData),
    .data_c  (fwd1_c)
  );

  fwd_mux u_fwd_rs2 (
    .addr    (idex_q.rs2),
    .rf_data (idex_q.rdata2),
    .mem_we  (MemRegWrite),
    .mem_rd  (MemRd),
    .mem_data(MemData),
    .wb_we   (WbRegWrite),
    .wb_rd   (WbRd),
    .wb_data (WbData),
    .data_c  (fwd2_c)
  );

  assign LoadUseStall = idex_q.valid && idex_q.mem_read && (idex_q.rd != REG_ZERO) &&
                        IdValid && ((idex_q.rd == IdRs1) ||
                                    ((idex_q.rd == IdRs2) && !IdUseImm));

  assign BranchTarget = idex_q.pc_next + idex_q.imm;

  // Branch resolution from the ALU zero flag of the instruction in EX
  always_comb begin
    BranchTaken = 1'b0;
    if (idex_q.valid) begin
      case (idex_q.branch)
        BR_JMP:  BranchTaken = 1'b1;
        BR_EQZ:  BranchTaken = Zero1;
        BR_NEZ:  BranchTaken = !Zero1;
        default: BranchTaken = 1'b0;
      endcase
    end
  end

  // ALU drive; an empty slot keeps the ALU computing 0 + 0
  always_comb begin
    Src1     = '0;
    Src2     = '0;
    AluCtrl1 = ALU_ADD;
    if (idex_q.valid) begin
      Src1 = fwd1_c;
      if (idex_q.branch != BR_NONE) begin
        AluCtrl1 = ALU_SUB;
      end else begin
        AluCtrl1 = idex_q.alu_ctrl;
        Src2     = idex_q.use_imm ? idex_q.imm : fwd2_c;
      end
    end
  end

  // A redirect or a load-use hazard inserts a fully cleared slot
  always_comb begin
    idex_d = '0;
    if (!BranchTaken && !LoadUseStall && IdValid) begin
      idex_d.valid     = 1'b1;
      idex_d.alu_ctrl  = alu_op_e'(IdAluCtrl);
      idex_d.rs1       = IdRs1;
      idex_d.rs2       = IdRs2;
      idex_d.rd        = IdRd;
      idex_d.rdata1    = IdRdata1;
      idex_d.rdata2    = IdRdata2;
      idex_d.imm       = IdImm;
      idex_d.pc_next   = IdPcNext;
      idex_d.use_imm   = IdUseImm;
      idex_d.reg_write = IdRegWrite;
      idex_d.mem_read  = IdMemRead;
      idex_d.mem_write = IdMemWrite;
      idex_d.branch    = br_e'(IdBranch);
    end
  end

  always_comb begin
    exmem_d            = '0;
    exmem_d.valid      = idex_q.valid;
    exmem_d.reg_write  = idex_q.valid && idex_q.reg_write;
    exmem_d.mem_read   = idex_q.valid && idex_q.mem_read;
    exmem_d.mem_write  = idex_q.valid && idex_q.mem_write;
    exmem_d.rd         = idex_q.rd;
    exmem_d.result     = Result1;
    exmem_d.store_data = fwd2_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
    end
  end

  assign ExMemValid     = exmem_q.valid;
  assign ExMemRegWrite  = exmem_q.reg_write;
  assign ExMemMemRead   = exmem_q.mem_read;
  assign ExMemMemWrite  = exmem_q.mem_write;
  assign ExMemResult    = exmem_q.result;
  assign ExMemStoreData = exmem_q.store_data;
  assign ExMemRd        = exmem_q.rd;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the stimulus thread queues cycle-tagged
// expectations, a negedge monitor compares whatever is due that cycle.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        IdValid, IdUseImm, IdRegWrite, IdMemRead, IdMemWrite;
  logic [2:0]  IdAluCtrl, IdRs1, IdRs2, IdRd;
  logic [15:0] IdRdata1, IdRdata2, IdImm, IdPcNext;
  logic [1:0]  IdBranch;
  logic        MemRegWrite, WbRegWrite;
  logic [2:0]  MemRd, WbRd;
  logic [15:0] MemData, WbData;
  logic [15:0] Src1, Src2, Result1, ExMemResult, ExMemStoreData, BranchTarget;
  logic [2:0]  AluCtrl1, ExMemRd;
  logic        Zero1, ExMemValid, ExMemRegWrite, ExMemMemRead, ExMemMemWrite;
  logic        BranchTaken, LoadUseStall;

  typedef struct {
    int          cyc;
    int          kind;   // 0 alu drive, 1 branch, 2 stall, 3 ex/mem
    logic [15:0] d0;
    logic [15:0] d1;
    logic [2:0]  rd;
    logic [3:0]  flags;
    logic        opt;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU sitting on the other side of the interface
  always_comb begin
    Result1 = '0;
    case (AluCtrl1)
      3'd0: Result1 = Src1 + Src2;
      3'd1: Result1 = Src1 - Src2;
      3'd2: Result1 = Src1 & Src2;
      3'd3: Result1 = Src1 | Src2;
      3'd4: Result1 = ~Src1;
      3'd5: Result1 = Src1 << Src2[3:0];
      3'd6: Result1 = 16'($signed(Src1) >>> Src2[3:0]);
      default: Result1 = Src1 >> Src2[3:0];
    endcase
  end
  assign Zero1 = (Result1 == 16'h0);

  ex_stage dut (
    .clk(clk), .rst(rst),
    .IdValid(IdValid), .IdAluCtrl(IdAluCtrl), .IdRs1(IdRs1), .IdRs2(IdRs2), .IdRd(IdRd),
    .IdRdata1(IdRdata1), .IdRdata2(IdRdata2), .IdImm(IdImm), .IdUseImm(IdUseImm),
    .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead), .IdMemWrite(IdMemWrite),
    .IdBranch(IdBranch), .IdPcNext(IdPcNext),
    .MemRegWrite(MemRegWrite), .MemRd(MemRd), .MemData(MemData),
    .WbRegWrite(WbRegWrite), .WbRd(WbRd), .WbData(WbData),
    .Src1(Src1), .Src2(Src2), .AluCtrl1(AluCtrl1), .Result1(Result1), .Zero1(Zero1),
    .ExMemValid(ExMemValid), .ExMemRegWrite(ExMemRegWrite), .ExMemMemRead(ExMemMemRead),
    .ExMemMemWrite(ExMemMemWrite), .ExMemResult(ExMemResult),
    .ExMemStoreData(ExMemStoreData), .ExMemRd(ExMemRd),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .LoadUseStall(LoadUseStall)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear;
    IdValid = 0; IdAluCtrl = 0; IdRs1 = 0; IdRs2 = 0; IdRd = 0;
    IdRdata1 = 0; IdRdata2 = 0; IdImm = 0; IdPcNext = 0; IdUseImm = 0;
    IdRegWrite = 0; IdMemRead = 0; IdMemWrite = 0; IdBranch = 0;
  endtask

  task automatic id_set(input logic [2:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [2:0] rd, input logic [15:0] d1, input logic [15:0] d2,
                        input logic [15:0] imm, input logic [15:0] pc, input logic uimm,
                        input logic rw, input logic mr, input logic mw, input logic [1:0] br);
    IdValid = 1; IdAluCtrl = op; IdRs1 = rs1; IdRs2 = rs2; IdRd = rd;
    IdRdata1 = d1; IdRdata2 = d2; IdImm = imm; IdPcNext = pc; IdUseImm = uimm;
    IdRegWrite = rw; IdMemRead = mr; IdMemWrite = mw; IdBranch = br;
  endtask

  task automatic fwd_set(input logic mw, input logic [2:0] mrd, input logic [15:0] md,
                         input logic ww, input logic [2:0] wrd, input logic [15:0] wd);
    MemRegWrite = mw; MemRd = mrd; MemData = md;
    WbRegWrite = ww; WbRd = wrd; WbData = wd;
  endtask

  task automatic push(input int c, input int k, input logic [15:0] d0, input logic [15:0] d1,
                      input logic [2:0] rd, input logic [3:0] fl, input logic opt);
    exp_t e;
    e.cyc = c; e.kind = k; e.d0 = d0; e.d1 = d1; e.rd = rd; e.flags = fl; e.opt = opt;
    sb.push_back(e);
  endtask

  task automatic exp_ex(input int c, input logic [15:0] s1, input logic [15:0] s2,
                        input logic [2:0] op);
    push(c, 0, s1, s2, op, 4'h0, 1'b0);
  endtask
  task automatic exp_br(input int c, input logic tk, input logic [15:0] tgt, input logic chk);
    push(c, 1, tgt, 16'h0, 3'd0, {3'b000, tk}, chk);
  endtask
  task automatic exp_stall(input int c, input logic st);
    push(c, 2, 16'h0, 16'h0, 3'd0, {3'b000, st}, 1'b0);
  endtask
  // flags = {valid, reg_write, mem_read, mem_write}; data checked when valid or full
  task automatic exp_mem(input int c, input logic [3:0] fl, input logic [15:0] res,
                         input logic [15:0] st, input logic [2:0] rd, input logic full);
    push(c, 3, res, st, rd, fl, full);
  endtask

  task automatic check(input exp_t e);
    logic [3:0] got;
    total++;
    case (e.kind)
      0: if (Src1 !== e.d0 || Src2 !== e.d1 || AluCtrl1 !== e.rd) begin
           bad++;
           $display("FAIL alu_drive cyc=%0d got src1=%h src2=%h op=%0d want src1=%h src2=%h op=%0d",
                    e.cyc, Src1, Src2, AluCtrl1, e.d0, e.d1, e.rd);
         end
      1: if (BranchTaken !== e.flags[0] || (e.opt && BranchTarget !== e.d0)) begin
           bad++;
           $display("FAIL branch cyc=%0d got taken=%b target=%h want taken=%b target=%h",
                    e.cyc, BranchTaken, BranchTarget, e.flags[0], e.d0);
         end
      2: if (LoadUseStall !== e.flags[0]) begin
           bad++;
           $display("FAIL load_use cyc=%0d got stall=%b want stall=%b",
                    e.cyc, LoadUseStall, e.flags[0]);
         end
      default: begin
        got = {ExMemValid, ExMemRegWrite, ExMemMemRead, ExMemMemWrite};
        if (got !== e.flags || ((e.flags[3] || e.opt) &&
            (ExMemResult !== e.d0 || ExMemStoreData !== e.d1 || ExMemRd !== e.rd))) begin
          bad++;
          $display("FAIL exmem cyc=%0d got ctl=%b res=%h st=%h rd=%0d want ctl=%b res=%h st=%h rd=%0d",
                   e.cyc, got, ExMemResult, ExMemStoreData, ExMemRd, e.flags, e.d0, e.d1, e.rd);
        end
      end
    endcase
  endtask

  // Monitor: compare every expectation due in the current cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i]);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missed cyc=%0d kind=%0d got no check want one", sb[i].cyc, sb[i].kind);
        sb.delete(i);
      end
    end
  end

  initial begin
    id_clear();
    fwd_set(0, 0, 0, 0, 0, 0);
    tick(); tick();
    // reset state
    exp_ex(cyc, 0, 0, 3'd0); exp_br(cyc, 0, 16'h0, 1); exp_stall(cyc, 0);
    exp_mem(cyc, 4'b0000, 0, 0, 0, 1);
    tick();
    rst = 1;
    // I1: ADD r1 = 5 + 3
    id_set(3'd0, 2, 0, 1, 16'h5, 0, 16'h3, 16'h1, 1, 1, 0, 0, 2'd0);
    exp_stall(cyc, 0); exp_ex(cyc + 1, 16'h5, 16'h3, 3'd0); exp_br(cyc + 1, 0, 16'h4, 1);
    exp_mem(cyc + 2, 4'b1100, 16'h8, 0, 1, 0);
    tick();
    // I2: ADD r2 <- r1, MEM and WB both hold r1 next cycle
    id_set(3'd0, 1, 0, 2, 16'h99, 0, 0, 0, 1, 1, 0, 0, 2'd0);
    exp_ex(cyc + 1, 16'h10, 0, 3'd0); exp_mem(cyc + 2, 4'b1100, 16'h10, 0, 2, 0);
    tick();
    // I3: same dependency, only WB will hold r1
    id_set(3'd0, 1, 0, 3, 16'h99, 0, 0, 0, 1, 1, 0, 0, 2'd0);
    fwd_set(1, 1, 16'h10, 1, 1, 16'h20);
    exp_ex(cyc + 1, 16'h20, 0, 3'd0); exp_mem(cyc + 2, 4'b1100, 16'h20, 0, 3, 0);
    tick();
    // I4: load r3 from r4 + 2
    id_set(3'd0, 4, 0, 3, 16'h40, 0, 16'h2, 0, 1, 1, 1, 0, 2'd0);
    fwd_set(0, 1, 16'h10, 1, 1, 16'h20);
    exp_ex(cyc + 1, 16'h40, 16'h2, 3'd0); exp_mem(cyc + 2, 4'b1110, 16'h42, 0, 3, 0);
    tick();
    // I5: ADD r5 = r3 + r1 right behind the load
    id_set(3'd0, 3, 1, 5, 16'h77, 16'h5, 0, 0, 0, 1, 0, 0, 2'd0);
    fwd_set(0, 0, 0, 0, 0, 0);
    exp_stall(cyc, 1); exp_stall(cyc + 1, 0); exp_ex(cyc + 1, 0, 0, 3'd0);
    exp_mem(cyc + 2, 4'b0000, 0, 0, 0, 0);
    tick();
    tick();
    // I5 now in EX; load data forwarded from WB
    id_clear();
    fwd_set(0, 0, 0, 1, 3, 16'h42);
    exp_ex(cyc, 16'h42, 16'h5, 3'd0); exp_stall(cyc, 0);
    exp_mem(cyc + 1, 4'b1100, 16'h47, 16'h5, 5, 0);
    tick();
    // B1: BEQZ r6, rs1 forwarded to zero
    id_set(3'd1, 6, 0, 0, 16'h55, 0, 16'hFFFC, 16'h10, 0, 0, 0, 0, 2'd1);
    fwd_set(0, 0, 0, 0, 0, 0);
    tick();
    id_set(3'd0, 1, 0, 7, 16'h1, 0, 16'h1, 0, 1, 1, 0, 0, 2'd0);
    fwd_set(1, 6, 16'h0, 0, 0, 0);
    exp_ex(cyc, 0, 0, 3'd1); exp_br(cyc, 1, 16'h000C, 1);
    exp_ex(cyc + 1, 0, 0, 3'd0); exp_br(cyc + 1, 0, 0, 0);
    exp_mem(cyc + 1, 4'b1000, 0, 0, 0, 0); exp_mem(cyc + 2, 4'b0000, 0, 0, 0, 0);
    tick();
    // B2: BEQZ with rs1 = 1, not taken
    id_set(3'd1, 6, 0, 0, 16'h1, 0, 16'hFFFC, 16'h10, 0, 0, 0, 0, 2'd1);
    fwd_set(0, 0, 0, 0, 0, 0);
    tick();
    exp_ex(cyc, 16'h1, 0, 3'd1); exp_br(cyc, 0, 16'h000C, 1);
    exp_mem(cyc + 1, 4'b1000, 16'h1, 0, 0, 0);
    // I7: rs1 = r0 with a bogus r0 forward, target wrap, WB-forwarded store data
    id_set(3'd0, 0, 5, 4, 16'h5555, 16'h3, 16'h2, 16'hFFFF, 1, 1, 0, 0, 2'd0);
    tick();
    fwd_set(1, 0, 16'hFFFF, 1, 5, 16'hBEEF);
    exp_ex(cyc, 0, 16'h2, 3'd0); exp_br(cyc, 0, 16'h0001, 1);
    exp_mem(cyc + 1, 4'b1100, 16'h2, 16'hBEEF, 4, 0);
    id_set(3'd0, 2, 0, 1, 16'h100, 0, 16'h1, 0, 1, 1, 0, 0, 2'd0);
    tick();
    fwd_set(0, 0, 0, 0, 0, 0);
    id_set(3'd0, 2, 0, 6, 16'h200, 0, 16'h1, 0, 1, 1, 1, 0, 2'd0);
    tick();
    // both pipeline registers valid; reset asserted between clock edges
    id_set(3'd0, 6, 0, 7, 16'h1, 0, 16'h1, 0, 1, 1, 0, 0, 2'd0);
    #1 rst = 0;
    exp_ex(cyc, 0, 0, 3'd0); exp_br(cyc, 0, 16'h0, 1); exp_stall(cyc, 0);
    exp_mem(cyc, 4'b0000, 0, 0, 0, 1);
    tick();
    exp_mem(cyc, 4'b0000, 0, 0, 0, 1);
    rst = 1;
    // I10: first capture after reset release
    id_set(3'd0, 2, 0, 2, 16'h7, 0, 16'h9, 0, 1, 1, 0, 0, 2'd0);
    exp_ex(cyc + 1, 16'h7, 16'h9, 3'd0); exp_mem(cyc + 1, 4'b0000, 0, 0, 0, 0);
    exp_mem(cyc + 2, 4'b1100, 16'h10, 0, 2, 0);
    tick();
    id_clear();
    repeat (4) tick();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got pending=%0d want pending=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
